run_controller: RTL and testbench

Execution controller for the 4-bit core: it gates the core clock enable `ce` so a host or testbench can halt the core, resume it, single-step or multi-step it, and stop it on an instruction-code breakpoint. It sits at the system top level between a host command port and the core (control, memory_unit, alu). The core only advances in cycles where `ce_out` is high.

---
 rtl/run_controller_pkg.sv | 22 ++
 rtl/run_controller.sv | 129 ++++++++++++
 tb/tb_run_controller.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/run_controller_pkg.sv
// Shared definitions for the run controller: host command opcodes and FSM states.
// The system top and the simulation accessors import this same package.
package run_controller_pkg;

    // Instruction code width of the 4-bit core.
    localparam int WORD_SIZE_DEF = 4;
    localparam int STEP_W_DEF    = 8;

    typedef enum logic [1:0] {
        OP_HALT   = 2'b00,
        OP_RUN    = 2'b01,
        OP_STEP   = 2'b10,
        OP_SET_BP = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_HALTED = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10
    } state_e;

endpackage

// File: rtl/run_controller.sv
// Execution controller: gates the core clock enable for halt, run, single/multi-step
// and instruction-code breakpoints, driven by a host command port.
module run_controller
    import run_controller_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int STEP_W    = STEP_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [STEP_W-1:0]    cmd_arg,
    input  logic [WORD_SIZE-1:0] instruction_code,
    output logic                 ce_out,
    output logic [1:0]           state,
    output logic                 bp_hit,
    output logic                 step_done
);

    state_e                state_q, state_d;
    logic [STEP_W-1:0]     cnt_q, cnt_d;
    logic                  skip_q, skip_d;
    logic                  bp_en_q, bp_en_d;
    logic [WORD_SIZE-1:0]  bp_val_q, bp_val_d;
    logic                  bp_hit_q, bp_hit_d;
    logic                  step_done_q, step_done_d;
    logic                  bp_match;

    // The comparator is purely combinational so the matching cycle never
    // reaches the core; skip masks it once after a resume.
    assign bp_match  = bp_en_q && !skip_q && (instruction_code == bp_val_q);
    assign ce_out    = (state_q != ST_HALTED) && !bp_match;
    assign cmd_ready = 1'b1;
    assign state     = state_q;
    assign bp_hit    = bp_hit_q;
    assign step_done = step_done_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        skip_d      = skip_q;
        bp_en_d     = bp_en_q;
        bp_val_d    = bp_val_q;
        bp_hit_d    = bp_hit_q;
        step_done_d = 1'b0;

        if (ce_out) begin
            skip_d = 1'b0;
        end

        unique case (state_q)
            ST_RUN: begin
                if (bp_match) begin
                    state_d  = ST_HALTED;
                    bp_hit_d = 1'b1;
                end
            end
            ST_STEP: begin
                if (bp_match) begin
                    state_d  = ST_HALTED;
                    bp_hit_d = 1'b1;
                end else if (cnt_q <= STEP_W'(1)) begin
                    // Last counted cycle: leave cnt at 1 so it never wraps.
                    state_d     = ST_HALTED;
                    step_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - STEP_W'(1);
                end
            end
            default: begin
            end
        endcase

        // An accepted command overrides the event-driven next state above.
        if (cmd_valid) begin
            unique case (op_e'(cmd_op))
                OP_HALT: begin
                    state_d = ST_HALTED;
                end
                OP_RUN: begin
                    state_d  = ST_RUN;
                    bp_hit_d = 1'b0;
                    skip_d   = 1'b1;
                end
                OP_STEP: begin
                    if (cmd_arg == '0) begin
                        state_d     = ST_HALTED;
                        step_done_d = 1'b1;
                    end else begin
                        state_d  = ST_STEP;
                        cnt_d    = cmd_arg;
                        bp_hit_d = 1'b0;
                        skip_d   = 1'b1;
                    end
                end
                OP_SET_BP: begin
                    bp_en_d  = cmd_arg[WORD_SIZE];
                    bp_val_d = cmd_arg[WORD_SIZE-1:0];
                    bp_hit_d = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HALTED;
            cnt_q       <= '0;
            skip_q      <= 1'b0;
            bp_en_q     <= 1'b0;
            bp_val_q    <= '0;
            bp_hit_q    <= 1'b0;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            skip_q      <= skip_d;
            bp_en_q     <= bp_en_d;
            bp_val_q    <= bp_val_d;
            bp_hit_q    <= bp_hit_d;
            step_done_q <= step_done_d;
        end
    end

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: per-cycle expected outputs go through a
// scoreboard queue and are compared half a cycle after the active edge.
module tb_run_controller;
    import run_controller_pkg::*;

    localparam int WS = 4;
    localparam int SW = 8;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [SW-1:0] cmd_arg;
    logic [WS-1:0] instruction_code;
    logic          ce_out;
    logic [1:0]    state;
    logic          bp_hit;
    logic          step_done;

    typedef struct {
        string      tag;
        logic       ce;
        logic [1:0] st;
        logic       hit;
        logic       sd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    run_controller #(.WORD_SIZE(WS), .STEP_W(SW)) dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_arg          (cmd_arg),
        .instruction_code (instruction_code),
        .ce_out           (ce_out),
        .state            (state),
        .bp_hit           (bp_hit),
        .step_done        (step_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue the expected outputs for the current cycle, sample, compare, advance.
    task automatic cyc(input string tag, input logic ce, input logic [1:0] st,
                       input logic hit, input logic sd);
        exp_t e;
        e.tag = tag; e.ce = ce; e.st = st; e.hit = hit; e.sd = sd;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        checks++;
        assert (ce_out === e.ce) else begin
            errors++;
            $error("FAIL %s ce_out: got %0b expected %0b", e.tag, ce_out, e.ce);
        end
        checks++;
        assert (state === e.st) else begin
            errors++;
            $error("FAIL %s state: got %0b expected %0b", e.tag, state, e.st);
        end
        checks++;
        assert (bp_hit === e.hit) else begin
            errors++;
            $error("FAIL %s bp_hit: got %0b expected %0b", e.tag, bp_hit, e.hit);
        end
        checks++;
        assert (step_done === e.sd) else begin
            errors++;
            $error("FAIL %s step_done: got %0b expected %0b", e.tag, step_done, e.sd);
        end
        checks++;
        assert (cmd_ready === 1'b1) else begin
            errors++;
            $error("FAIL %s cmd_ready: got %0b expected 1", e.tag, cmd_ready);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] op, input logic [SW-1:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        $display("[%0t] cmd op=%0d arg=0x%02h ic=0x%0h", $time, op, arg, instruction_code);
    endtask

    task automatic idle_cmd();
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_arg   = '0;
    endtask

    initial begin
        reset            = 1'b1;
        cmd_valid        = 1'b0;
        cmd_op           = 2'b00;
        cmd_arg          = '0;
        instruction_code = '0;
        @(posedge clk);
        @(negedge clk);

        // Reset held, then ten idle cycles.
        cyc("reset", 1'b0, 2'b00, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) cyc("idle", 1'b0, 2'b00, 1'b0, 1'b0);

        // STEP 3.
        send(OP_STEP, 8'd3);
        cyc("step3_t", 1'b0, 2'b00, 1'b0, 1'b0);
        idle_cmd();
        for (int i = 0; i < 3; i++) cyc("step3_ce", 1'b1, 2'b10, 1'b0, 1'b0);
        cyc("step3_done", 1'b0, 2'b00, 1'b0, 1'b1);
        cyc("step3_after", 1'b0, 2'b00, 1'b0, 1'b0);

        // STEP 0: immediate step_done, no ce.
        send(OP_STEP, 8'd0);
        cyc("step0_t", 1'b0, 2'b00, 1'b0, 1'b0);
        idle_cmd();
        cyc("step0_done", 1'b0, 2'b00, 1'b0, 1'b1);
        cyc("step0_after", 1'b0, 2'b00, 1'b0, 1'b0);

        // Breakpoint on 0xA, run into it.
        send(OP_SET_BP, 8'h1A);
        cyc("setbp", 1'b0, 2'b00, 1'b0, 1'b0);
        instruction_code = 4'h3;
        send(OP_RUN, 8'd0);
        cyc("run_t", 1'b0, 2'b00, 1'b0, 1'b0);
        idle_cmd();
        for (int i = 0; i < 3; i++) cyc("run_ce", 1'b1, 2'b01, 1'b0, 1'b0);
        instruction_code = 4'hA;
        cyc("bp_match", 1'b0, 2'b01, 1'b0, 1'b0);
        cyc("bp_halted", 1'b0, 2'b00, 1'b1, 1'b0);

        // Resume while sitting on the breakpoint: executes once, no re-trap.
        send(OP_RUN, 8'd0);
        cyc("resume_t", 1'b0, 2'b00, 1'b1, 1'b0);
        idle_cmd();
        cyc("resume_skip", 1'b1, 2'b01, 1'b0, 1'b0);
        instruction_code = 4'h5;
        cyc("resume_run", 1'b1, 2'b01, 1'b0, 1'b0);
        send(OP_HALT, 8'd0);
        cyc("halt_t", 1'b1, 2'b01, 1'b0, 1'b0);
        idle_cmd();
        cyc("halt_done", 1'b0, 2'b00, 1'b0, 1'b0);

        // HALT in the same cycle as a breakpoint match still records bp_hit.
        instruction_code = 4'h0;
        send(OP_RUN, 8'd0);
        cyc("run2_t", 1'b0, 2'b00, 1'b0, 1'b0);
        idle_cmd();
        cyc("run2_ce", 1'b1, 2'b01, 1'b0, 1'b0);
        instruction_code = 4'hA;
        send(OP_HALT, 8'd0);
        cyc("halt_bp_t", 1'b0, 2'b01, 1'b0, 1'b0);
        idle_cmd();
        cyc("halt_bp", 1'b0, 2'b00, 1'b1, 1'b0);

        // Disable the breakpoint; bp_hit clears.
        send(OP_SET_BP, 8'h00);
        cyc("clrbp_t", 1'b0, 2'b00, 1'b1, 1'b0);
        idle_cmd();
        cyc("clrbp", 1'b0, 2'b00, 1'b0, 1'b0);

        // STEP 5 with HALT coinciding with the final counted cycle.
        send(OP_STEP, 8'd5);
        cyc("step5_t", 1'b0, 2'b00, 1'b0, 1'b0);
        idle_cmd();
        for (int i = 0; i < 4; i++) cyc("step5_ce", 1'b1, 2'b10, 1'b0, 1'b0);
        send(OP_HALT, 8'd0);
        cyc("step5_last", 1'b1, 2'b10, 1'b0, 1'b0);
        idle_cmd();
        cyc("step5_done", 1'b0, 2'b00, 1'b0, 1'b1);
        cyc("step5_after", 1'b0, 2'b00, 1'b0, 1'b0);

        // STEP 200 aborted by reset after 50 ce cycles.
        send(OP_STEP, 8'd200);
        cyc("step200_t", 1'b0, 2'b00, 1'b0, 1'b0);
        idle_cmd();
        for (int i = 0; i < 50; i++) cyc("step200_ce", 1'b1, 2'b10, 1'b0, 1'b0);
        reset = 1'b1;
        cyc("step200_rst", 1'b1, 2'b10, 1'b0, 1'b0);
        reset = 1'b0;
        cyc("post_rst", 1'b0, 2'b00, 1'b0, 1'b0);
        cyc("post_rst2", 1'b0, 2'b00, 1'b0, 1'b0);

        // STEP 255: maximum count, exactly 255 enabled cycles.
        send(OP_STEP, 8'd255);
        cyc("step255_t", 1'b0, 2'b00, 1'b0, 1'b0);
        idle_cmd();
        for (int i = 0; i < 255; i++) cyc("step255_ce", 1'b1, 2'b10, 1'b0, 1'b0);
        cyc("step255_done", 1'b0, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc("step255_after", 1'b0, 2'b00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
